uart_tx_frame: RTL

UART transmitter frame engine for the system UART, the transmit-side counterpart of the receive path. It accepts a parallel byte with a valid strobe and serialises it onto TX_OUT as start bit, LSB-first data, optional parity and stop bit. It runs at one CLK cycle per bit; CLK is the already-divided TX bit clock from the clock-divider block. Parity convention matches the receiver: PAR_TYP=0 even, PAR_TYP=1 odd.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_frame_if.sv | 22 ++
 rtl/uart_tx_serializer.sv | 44 ++++
 rtl/uart_tx_frame.sv | 123 ++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, line levels and the parity-type
// encoding that the TX engine and the RX parity checker both use.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic UART_IDLE_LVL = 1'b1;
    localparam logic START_LVL     = 1'b0;
    localparam logic STOP_LVL      = 1'b1;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_frame_if.sv
// Byte-request / serial-line bundle between a UART client (master) and the
// TX frame engine (slave).
interface uart_tx_frame_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        input  TX_OUT, Busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        output TX_OUT, Busy
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// Holding register plus saturating bit counter; presents the current payload
// bit LSB first and flags the last bit so the FSM can leave DATA.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8,
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic                  clr,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  bit_o,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] data_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] data_r;
    logic [CNT_W-1:0]      cnt_r;

    // Payload capture and bit counter; the counter parks on the last index.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            data_r <= '0;
            cnt_r  <= '0;
        end else begin
            if (load) begin
                data_r <= din;
            end
            if (clr) begin
                cnt_r <= '0;
            end else if (shift && (cnt_r != LAST_CNT)) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign bit_o  = data_r[cnt_r];
    assign done   = (cnt_r == LAST_CNT);
    assign data_o = data_r;

endmodule

// File: rtl/uart_tx_frame.sv
// UART TX frame engine: one CLK per bit, start / LSB-first data / optional
// parity / stop. TX_OUT and Busy are registered decodes of the current state.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic              CLK,
    input  logic              RST,
    uart_tx_frame_if.slave    bus
);

    tx_state_e             state_r;
    tx_state_e             next_s;
    logic                  par_en_r;
    logic                  par_typ_r;
    logic                  tx_r;
    logic                  busy_r;
    logic                  tx_nxt_s;
    logic                  busy_nxt_s;
    logic                  load_s;
    logic                  clr_s;
    logic                  shift_s;
    logic                  ser_bit_s;
    logic                  ser_done_s;
    logic [DATA_WIDTH-1:0] held_data_s;
    logic                  par_bit_s;

    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d,
                                         input logic                  typ);
        case (typ)
            PAR_EVEN: calc_parity = ^d;
            PAR_ODD:  calc_parity = ~^d;
            default:  calc_parity = ^d;
        endcase
    endfunction

    uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
        .CLK    (CLK),
        .RST    (RST),
        .load   (load_s),
        .clr    (clr_s),
        .shift  (shift_s),
        .din    (bus.P_DATA),
        .bit_o  (ser_bit_s),
        .done   (ser_done_s),
        .data_o (held_data_s)
    );

    assign par_bit_s = calc_parity(held_data_s, par_typ_r);

    // State, frame configuration and registered line outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r   <= IDLE;
            par_en_r  <= 1'b0;
            par_typ_r <= 1'b0;
            tx_r      <= UART_IDLE_LVL;
            busy_r    <= 1'b0;
        end else begin
            state_r <= next_s;
            tx_r    <= tx_nxt_s;
            busy_r  <= busy_nxt_s;
            if (load_s) begin
                par_en_r  <= bus.PAR_EN;
                par_typ_r <= bus.PAR_TYP;
            end
        end
    end

    // Next state, serializer control and the line level for the current state.
    always_comb begin
        next_s     = state_r;
        load_s     = 1'b0;
        clr_s      = 1'b0;
        shift_s    = 1'b0;
        tx_nxt_s   = UART_IDLE_LVL;
        busy_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.Data_Valid) begin
                    load_s = 1'b1;
                    next_s = START;
                end else begin
                    next_s = IDLE;
                end
            end
            START: begin
                tx_nxt_s   = START_LVL;
                busy_nxt_s = 1'b1;
                clr_s      = 1'b1;
                next_s     = DATA;
            end
            DATA: begin
                tx_nxt_s   = ser_bit_s;
                busy_nxt_s = 1'b1;
                shift_s    = 1'b1;
                if (ser_done_s) begin
                    next_s = par_en_r ? PARITY : STOP;
                end else begin
                    next_s = DATA;
                end
            end
            PARITY: begin
                tx_nxt_s   = par_bit_s;
                busy_nxt_s = 1'b1;
                next_s     = STOP;
            end
            STOP: begin
                tx_nxt_s   = STOP_LVL;
                busy_nxt_s = 1'b1;
                next_s     = IDLE;
            end
            default: begin
                next_s = IDLE;
            end
        endcase
    end

    assign bus.TX_OUT = tx_r;
    assign bus.Busy   = busy_r;

endmodule
